ofm_residual_buffer: RTL and testbench
======================================

# ofm_residual_buffer

Parametrised output-feature-map and membrane-residue store for one SNN layer. It holds an 8-bit residue and a 1-bit spike per neuron for `N_CH` output channels of a `DEPTH_F`×`DEPTH_F` map. Per timestep it accumulates partial sums from the PE array, thresholds them with soft reset, and writes back the residue. It streams {channel, address, spike, residue} packets to the NoC packetiser, and also supports bulk residue preload and drain between timesteps.

## Interface
- `DEPTH_F`, 21: map side; `NPIX = DEPTH_F*DEPTH_F`.
- `N_CH`, 4: output channels stored.
- `WIDTH_RES`, 8: residue width, unsigned.
- `WIDTH_PSUM`, 13: partial-sum width, signed two's complement.
- `THRESHOLD`, 64: firing threshold, unsigned, < 2^WIDTH_RES.
- Derived widths:
  - `ADDR_W = $clog2(NPIX)`
  - `CH_W = max(1,$clog2(N_CH))`
  - `PKT_W = CH_W+ADDR_W+1+WIDTH_RES` (20 at defaults)
- Ports:
  - `clk`, in, 1: sole clock, rising edge.
  - `rst`, in, 1: asynchronous, active-high reset.
  - `cmd_valid`, in, 1 / `cmd_ready`, out, 1: command handshake.
  - `cmd_op`, in, 2: 0 CLEAR, 1 LOAD, 2 STEP, 3 DRAIN.
  - `cmd_ch`, in, CH_W: target channel; ignored by CLEAR.
  - `in_valid`, in, 1 / `in_ready`, out, 1: input stream handshake.
  - `in_data`, in, WIDTH_PSUM: psum (STEP) or residue in bits [WIDTH_RES-1:0] (LOAD).
  - `out_valid`, in/out: out, 1 / `out_ready`, in, 1: output packet handshake.
  - `out_data`, out, PKT_W: {ch, addr, spike, residue}, with ch in the MSBs.
  - `busy`, out, 1: state ≠ IDLE.
  - `done`, out, 1: one-cycle pulse on command completion.

## Operation
- Storage is a register array, `N_CH`×`NPIX` entries of {spike, residue}, with combinational read and write on the clock edge.
- FSM states: IDLE, CLEAR, LOAD, STEP, DRAIN.
- IDLE:
  - `cmd_ready=1`.
  - On a `cmd_valid` handshake, latch op and ch, set the address counter to 0, and go to the op's state.
  - Commands presented while not in IDLE are not accepted (`cmd_ready=0`).
- CLEAR: all channels' residues and spikes become 0 in one cycle. Pulse `done`, then return to IDLE.
- LOAD:
  - `in_ready=1`.
  - Each accepted word writes residue[ch][addr] = `in_data[WIDTH_RES-1:0]`, sets spike to 0, and increments addr.
  - No output is produced.
  - After accepting word NPIX-1: pulse `done`, go to IDLE.
- STEP, per accepted psum p at addr a:
  - Compute `v = residue + sext(p)` at WIDTH_PSUM+1 bits signed.
  - If v<0 then v=0.
  - If v ≥ THRESHOLD: spike=1 and v -= THRESHOLD. Otherwise spike=0.
  - Saturate v at 2^WIDTH_RES−1.
  - Write {spike, v} and load the output register with {ch, a, spike, v} on the same edge.
- DRAIN: emit {ch, addr, stored spike, stored residue} for addr 0..NPIX−1. Storage is unchanged.
- Completion of STEP and DRAIN:
  - `done` pulses in the cycle after the output handshake of packet NPIX−1.
  - The FSM goes to IDLE in that same cycle.
- Inputs arrive in raster order. Addr increments on each accepted word and never wraps inside a command.

## Timing
- Reset:
  - Outputs: `out_valid=0`, `out_data=0`, `in_ready=0`, `cmd_ready=1` (in IDLE), `busy=0`, `done=0`.
  - Storage: all entries = 0.
  - Takes effect immediately and asynchronously, including mid-command. Partial progress is discarded and no stale packet is emitted.
- Output register is one stage:
  - An input accepted at edge k gives `out_valid=1` from edge k.
  - `out_data` is held stable until `out_ready`.
- STEP backpressure:
  - `in_ready = (state==STEP) && (!out_valid || out_ready)`.
  - Throughput is 1 element/cycle with `out_ready` held high.
  - A simultaneous output handshake and new input in one cycle is legal and is required for full rate.
- DRAIN: the same rule applies. Read-and-load occurs whenever `!out_valid || out_ready`, and addr < NPIX.
- Command timing: a command is accepted at the earliest in the cycle after `done`. There is no back-to-back overlap.
- `in_valid` is ignored outside LOAD and STEP. Data presented then is not consumed.

## Test plan
- Reset → DRAIN ch0:
  - 441 packets, addr 0..440, spike 0, residue 0, ch 0.
  - `done` pulses once after addr 440; `cmd_ready` is 1 the following cycle.
- LOAD ch1 with residue = addr mod 256, then STEP ch1 with psum=+10 everywhere:
  - addr 5: spike 0, residue 15.
  - addr 60: spike 1, residue 6.
  - addr 250: spike 1, residue 196.
  - addr 255: spike 1, residue 201.
- Saturation and negative clamp (LOAD addr0=255, addr1=3):
  - psum +200 at addr0: spike 1, residue 255.
  - psum −20 at addr1: spike 0, residue 0.
  - psum −4096 at addr2: residue 0.
- Backpressure: STEP with `out_ready` high 1 cycle in 3 and random `in_valid`.
  - Exactly 441 packets, in order, none duplicated or lost.
  - `in_ready` is 0 whenever `out_valid && !out_ready`.
  - `out_data` stays stable while stalled.
- Channel isolation: LOAD ch3=77, STEP ch2 with psum=+100, then DRAIN ch3.
  - All residues are 77 and all spikes 0.
  - CLEAR then zeroes ch2 and ch3.
- Reset asserted mid-STEP, just after element 100 is accepted:
  - `out_valid` drops without waiting for a clock edge; `busy=0`; `cmd_ready=1`.
  - A subsequent DRAIN returns all zeros.
  - A command issued during STEP is not accepted (`cmd_ready=0`).

Source files
------------

// File: rtl/ofm_residual_buffer.sv
// ----------------------------------------------------------------------------
// ofm_residual_buffer
//
// Output-feature-map and membrane-residue store for one SNN layer. Each of
// N_CH channels holds DEPTH_F*DEPTH_F neurons of {spike, residue}. A command
// selects one of four operations:
//   CLEAR : zero every entry of every channel in one cycle
//   LOAD  : stream residues into one channel (raster order, no output)
//   STEP  : accumulate psums into one channel, threshold with soft reset,
//           write back and emit {ch, addr, spike, residue} packets
//   DRAIN : emit the stored contents of one channel, storage unchanged
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (accepted only when idle)
//   cmd_op [1:0], cmd_ch [CH_W]   0 CLEAR, 1 LOAD, 2 STEP, 3 DRAIN; channel
//   in_valid/in_ready, in_data    psum (STEP) or residue in low bits (LOAD)
//   out_valid/out_ready, out_data packet {ch, addr, spike, residue}, ch in MSBs
//   busy                          any state other than IDLE
//   done                          one-cycle pulse when a command completes
// ----------------------------------------------------------------------------
module ofm_residual_buffer #(
  parameter int DEPTH_F    = 21,
  parameter int N_CH       = 4,
  parameter int WIDTH_RES  = 8,
  parameter int WIDTH_PSUM = 13,
  parameter int THRESHOLD  = 64,
  localparam int NPIX   = DEPTH_F * DEPTH_F,
  localparam int ADDR_W = $clog2(NPIX),
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int PKT_W  = CH_W + ADDR_W + 1 + WIDTH_RES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [CH_W-1:0]       cmd_ch,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH_PSUM-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PKT_W-1:0]      out_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_STEP, S_DRAIN
  } state_t;

  // One extra counter bit so "all NPIX elements consumed" is representable
  // even when NPIX is a power of two.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] NPIX_C = CNT_W'(NPIX);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NPIX - 1);
  localparam logic signed [WIDTH_PSUM:0] TH_S    = (WIDTH_PSUM+1)'(THRESHOLD);
  localparam logic signed [WIDTH_PSUM:0] RES_MAX = (WIDTH_PSUM+1)'((1 << WIDTH_RES) - 1);

  state_t              r_state;
  logic [CH_W-1:0]     r_ch;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done;
  logic                r_out_valid;
  logic [PKT_W-1:0]    r_out_data;
  logic [WIDTH_RES:0]  r_mem [N_CH][NPIX];   // {spike, residue}

  logic                     w_cmd_ready;
  logic                     w_room;
  logic                     w_in_ready;
  logic                     w_in_fire;
  logic                     w_out_load;
  logic                     w_last_hs;
  logic [ADDR_W-1:0]        w_addr;
  logic [WIDTH_RES:0]       w_entry;
  logic signed [WIDTH_PSUM:0] w_sum;
  logic signed [WIDTH_PSUM:0] w_clamp;
  logic signed [WIDTH_PSUM:0] w_sub;
  logic                     w_spike;
  logic [WIDTH_RES-1:0]     w_res;
  logic [PKT_W-1:0]         w_pkt;

  assign w_addr  = r_cnt[ADDR_W-1:0];
  assign w_entry = r_mem[r_ch][w_addr];

  // The output register can take a new packet when it is empty or draining
  // this cycle; this is what lets STEP/DRAIN run at one element per cycle.
  assign w_room = !r_out_valid || out_ready;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_cmd_ready = 1'b0;
    w_in_ready  = 1'b0;
    w_out_load  = 1'b0;
    w_last_hs   = 1'b0;
    unique case (r_state)
      // A command is never taken in the same cycle as the previous done.
      S_IDLE:  w_cmd_ready = !r_done;
      S_LOAD:  w_in_ready  = 1'b1;
      S_STEP: begin
        w_in_ready = w_room && (r_cnt < NPIX_C);
        w_out_load = in_valid && w_in_ready;
        w_last_hs  = r_out_valid && out_ready && (r_cnt == NPIX_C);
      end
      S_DRAIN: begin
        w_out_load = w_room && (r_cnt < NPIX_C);
        w_last_hs  = r_out_valid && out_ready && (r_cnt == NPIX_C);
      end
      default: ;
    endcase
  end

  assign w_in_fire = in_valid && w_in_ready;

  // Neuron update: residue + sign-extended psum, clamp at zero, soft-reset
  // threshold, then saturate to the residue width.
  always_comb begin
    w_sum   = $signed({{(WIDTH_PSUM+1-WIDTH_RES){1'b0}}, w_entry[WIDTH_RES-1:0]})
            + $signed({in_data[WIDTH_PSUM-1], in_data});
    w_clamp = w_sum[WIDTH_PSUM] ? '0 : w_sum;
    w_spike = (w_clamp >= TH_S);
    w_sub   = w_spike ? (w_clamp - TH_S) : w_clamp;
    w_res   = (w_sub > RES_MAX) ? {WIDTH_RES{1'b1}} : w_sub[WIDTH_RES-1:0];
    w_pkt   = (r_state == S_STEP) ? {r_ch, w_addr, w_spike, w_res}
                                  : {r_ch, w_addr, w_entry};
  end

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_done <= 1'b0;

      if (w_out_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pkt;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_valid && w_cmd_ready) begin
            r_ch  <= cmd_ch;
            r_cnt <= '0;
            case (cmd_op)
              2'd0:    r_state <= S_CLEAR;
              2'd1:    r_state <= S_LOAD;
              2'd2:    r_state <= S_STEP;
              default: r_state <= S_DRAIN;
            endcase
          end
        end
        S_CLEAR: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        S_LOAD: begin
          if (w_in_fire) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_C) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_STEP, S_DRAIN: begin
          if (w_out_load) r_cnt <= r_cnt + 1'b1;
          // Completion waits for the last packet to leave, not just be loaded.
          if (w_last_hs) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the neuron store is reset explicitly because the layer's membrane
  // state must start from zero; it is a flop array, not an SRAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++)
        for (int a = 0; a < NPIX; a++)
          r_mem[c][a] <= '0;
    end else if (r_state == S_CLEAR) begin
      for (int c = 0; c < N_CH; c++)
        for (int a = 0; a < NPIX; a++)
          r_mem[c][a] <= '0;
    end else if (w_in_fire && (r_state == S_LOAD)) begin
      r_mem[r_ch][w_addr] <= {1'b0, in_data[WIDTH_RES-1:0]};
    end else if (w_in_fire && (r_state == S_STEP)) begin
      r_mem[r_ch][w_addr] <= {w_spike, w_res};
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_ofm_residual_buffer.sv
// ----------------------------------------------------------------------------
// Directed bench for ofm_residual_buffer at default parameters
// (21x21 map, 4 channels, 8-bit residue, 13-bit psum, threshold 64).
// A shadow copy of the store predicts STEP and DRAIN packets.
// ----------------------------------------------------------------------------
module tb_ofm_residual_buffer;

  localparam int NPIX = 441;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_ch;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  ofm_residual_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ch    (cmd_ch),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          shadow [4][NPIX];
  int          pv     [NPIX];
  logic [12:0] vec    [NPIX];
  logic [19:0] pkts   [$];
  int done_cnt, stall_err, stab_err, timeout_hit;

  function automatic logic [19:0] pkt(input int ch, input int addr,
                                      input int spk, input int res);
    logic [1:0] c; logic [8:0] a; logic s; logic [7:0] r;
    c = ch[1:0]; a = addr[8:0]; s = spk[0]; r = res[7:0];
    return {c, a, s, r};
  endfunction

  function automatic void model(input int res, input int p,
                                output int spk, output int nres);
    int v;
    v = res + p;
    if (v < 0) v = 0;
    if (v >= 64) begin spk = 1; v = v - 64; end
    else spk = 0;
    if (v > 255) v = 255;
    nres = v;
  endfunction

  task automatic set_word(input int i, input int p);
    pv[i]  = p;
    vec[i] = 13'(p);
  endtask

  task automatic clear_shadow();
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < NPIX; a++) shadow[c][a] = 0;
  endtask

  // Starts and ends just after a rising edge.
  task automatic send_cmd(input logic [1:0] op, input logic [1:0] ch);
    int k;
    cmd_op = op; cmd_ch = ch; cmd_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      #1;
      if (cmd_ready) break;
      @(posedge clk); #1;
    end
    n_checks++;
    if (k == 50) begin
      n_fail++;
      $display("FAIL cmd_accept: op=%0d ch=%0d not accepted within 50 cycles", op, ch);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Drives vec[] (when feed) and collects packets until done or timeout.
  task automatic stream(input bit feed, input bit bp);
    int idx; int cyc; bit stalled; logic [19:0] held;
    idx = 0; cyc = 0; stalled = 0; held = '0;
    pkts.delete();
    done_cnt = 0; stall_err = 0; stab_err = 0; timeout_hit = 0;
    while (done_cnt == 0) begin
      if (cyc > 5000) begin timeout_hit = 1; break; end
      in_valid  = feed && (idx < NPIX) && (!bp || ($urandom_range(0, 1) == 1));
      in_data   = (idx < NPIX) ? vec[idx] : '0;
      out_ready = !bp || (cyc % 3 == 0);
      #1;
      if (stalled && (out_data !== held)) stab_err++;
      if (out_valid && !out_ready) begin
        stalled = 1; held = out_data;
        if (in_ready !== 1'b0) stall_err++;
      end else stalled = 0;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) pkts.push_back(out_data);
      if (done) done_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ch = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    clear_shadow();
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 20'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    rst = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_drain_zero();
    send_cmd(2'd3, 2'd0);
    stream(1'b0, 1'b0);
    n_checks++; if (timeout_hit || done_cnt != 1) begin n_fail++; $display("FAIL drain0_done: timeout=%0d pulses=%0d want 0/1", timeout_hit, done_cnt); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL drain0_done_once: got %b want 0", done); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL drain0_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++; if (pkts.size() != NPIX) begin n_fail++; $display("FAIL drain0_count: got %0d want %0d", pkts.size(), NPIX); end
    for (int i = 0; i < pkts.size() && i < NPIX; i++) begin
      n_checks++;
      if (pkts[i] !== pkt(0, i, 0, 0)) begin n_fail++; $display("FAIL drain0_pkt[%0d]: got %h want %h", i, pkts[i], pkt(0, i, 0, 0)); end
    end
  endtask

  task automatic test_load_step();
    int s, r;
    for (int i = 0; i < NPIX; i++) set_word(i, i % 256);
    send_cmd(2'd1, 2'd1);
    stream(1'b1, 1'b0);
    n_checks++; if (timeout_hit || done_cnt != 1) begin n_fail++; $display("FAIL load1_done: timeout=%0d pulses=%0d want 0/1", timeout_hit, done_cnt); end
    n_checks++; if (pkts.size() != 0) begin n_fail++; $display("FAIL load1_no_output: got %0d packets want 0", pkts.size()); end
    for (int i = 0; i < NPIX; i++) shadow[1][i] = i % 256;

    for (int i = 0; i < NPIX; i++) set_word(i, 10);
    send_cmd(2'd2, 2'd1);
    stream(1'b1, 1'b0);
    n_checks++; if (timeout_hit || done_cnt != 1) begin n_fail++; $display("FAIL step1_done: timeout=%0d pulses=%0d want 0/1", timeout_hit, done_cnt); end
    n_checks++; if (pkts.size() != NPIX) begin n_fail++; $display("FAIL step1_count: got %0d want %0d", pkts.size(), NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      model(shadow[1][i], pv[i], s, r);
      shadow[1][i] = s * 256 + r;
      if (i < pkts.size()) begin
        n_checks++;
        if (pkts[i] !== pkt(1, i, s, r)) begin n_fail++; $display("FAIL step1_pkt[%0d]: got %h want %h", i, pkts[i], pkt(1, i, s, r)); end
      end
    end
    if (pkts.size() == NPIX) begin
      n_checks++; if (pkts[5]   !== pkt(1, 5,   0, 15))  begin n_fail++; $display("FAIL step1_a5: got %h want %h",   pkts[5],   pkt(1, 5, 0, 15)); end
      n_checks++; if (pkts[60]  !== pkt(1, 60,  1, 6))   begin n_fail++; $display("FAIL step1_a60: got %h want %h",  pkts[60],  pkt(1, 60, 1, 6)); end
      n_checks++; if (pkts[250] !== pkt(1, 250, 1, 196)) begin n_fail++; $display("FAIL step1_a250: got %h want %h", pkts[250], pkt(1, 250, 1, 196)); end
      n_checks++; if (pkts[255] !== pkt(1, 255, 1, 201)) begin n_fail++; $display("FAIL step1_a255: got %h want %h", pkts[255], pkt(1, 255, 1, 201)); end
    end
  endtask

  task automatic test_saturation();
    int s, r;
    for (int i = 0; i < NPIX; i++) set_word(i, 0);
    set_word(0, 255); set_word(1, 3);
    send_cmd(2'd1, 2'd0);
    stream(1'b1, 1'b0);
    n_checks++; if (timeout_hit || done_cnt != 1) begin n_fail++; $display("FAIL load0_done: timeout=%0d pulses=%0d want 0/1", timeout_hit, done_cnt); end
    for (int i = 0; i < NPIX; i++) shadow[0][i] = pv[i];

    for (int i = 0; i < NPIX; i++) set_word(i, (i % 97) - 40);
    set_word(0, 200); set_word(1, -20); set_word(2, -4096);
    send_cmd(2'd2, 2'd0);
    stream(1'b1, 1'b0);
    n_checks++; if (timeout_hit || done_cnt != 1) begin n_fail++; $display("FAIL sat_done: timeout=%0d pulses=%0d want 0/1", timeout_hit, done_cnt); end
    n_checks++; if (pkts.size() != NPIX) begin n_fail++; $display("FAIL sat_count: got %0d want %0d", pkts.size(), NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      model(shadow[0][i] % 256, pv[i], s, r);
      shadow[0][i] = s * 256 + r;
      if (i < pkts.size()) begin
        n_checks++;
        if (pkts[i] !== pkt(0, i, s, r)) begin n_fail++; $display("FAIL sat_pkt[%0d]: got %h want %h", i, pkts[i], pkt(0, i, s, r)); end
      end
    end
    if (pkts.size() == NPIX) begin
      n_checks++; if (pkts[0] !== pkt(0, 0, 1, 255)) begin n_fail++; $display("FAIL sat_a0: got %h want %h", pkts[0], pkt(0, 0, 1, 255)); end
      n_checks++; if (pkts[1] !== pkt(0, 1, 0, 0))   begin n_fail++; $display("FAIL clamp_a1: got %h want %h", pkts[1], pkt(0, 1, 0, 0)); end
      n_checks++; if (pkts[2] !== pkt(0, 2, 0, 0))   begin n_fail++; $display("FAIL clamp_a2: got %h want %h", pkts[2], pkt(0, 2, 0, 0)); end
    end
  endtask

  task automatic test_backpressure();
    int s, r;
    for (int i = 0; i < NPIX; i++) set_word(i, ((i * 13) % 150) - 60);
    send_cmd(2'd2, 2'd1);
    stream(1'b1, 1'b1);
    n_checks++; if (timeout_hit || done_cnt != 1) begin n_fail++; $display("FAIL bp_done: timeout=%0d pulses=%0d want 0/1", timeout_hit, done_cnt); end
    n_checks++; if (pkts.size() != NPIX) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", pkts.size(), NPIX); end
    n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_in_ready_stall: %0d cycles with in_ready=1 while stalled, want 0", stall_err); end
    n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL bp_out_stable: %0d cycles with out_data changed while stalled, want 0", stab_err); end
    for (int i = 0; i < NPIX; i++) begin
      model(shadow[1][i] % 256, pv[i], s, r);
      shadow[1][i] = s * 256 + r;
      if (i < pkts.size()) begin
        n_checks++;
        if (pkts[i] !== pkt(1, i, s, r)) begin n_fail++; $display("FAIL bp_pkt[%0d]: got %h want %h", i, pkts[i], pkt(1, i, s, r)); end
      end
    end
  endtask

  task automatic test_channel_isolation();
    int s, r, w;
    for (int i = 0; i < NPIX; i++) set_word(i, 77);
    send_cmd(2'd1, 2'd3);
    stream(1'b1, 1'b0);
    n_checks++; if (timeout_hit || done_cnt != 1) begin n_fail++; $display("FAIL load3_done: timeout=%0d pulses=%0d want 0/1", timeout_hit, done_cnt); end

    for (int i = 0; i < NPIX; i++) set_word(i, 100);
    send_cmd(2'd2, 2'd2);
    stream(1'b1, 1'b0);
    n_checks++; if (pkts.size() != NPIX) begin n_fail++; $display("FAIL step2_count: got %0d want %0d", pkts.size(), NPIX); end
    for (int i = 0; i < NPIX && i < pkts.size(); i++) begin
      model(0, 100, s, r);
      n_checks++;
      if (pkts[i] !== pkt(2, i, s, r)) begin n_fail++; $display("FAIL step2_pkt[%0d]: got %h want %h", i, pkts[i], pkt(2, i, s, r)); end
    end

    send_cmd(2'd3, 2'd3);
    stream(1'b0, 1'b0);
    n_checks++; if (pkts.size() != NPIX) begin n_fail++; $display("FAIL drain3_count: got %0d want %0d", pkts.size(), NPIX); end
    for (int i = 0; i < NPIX && i < pkts.size(); i++) begin
      n_checks++;
      if (pkts[i] !== pkt(3, i, 0, 77)) begin n_fail++; $display("FAIL drain3_pkt[%0d]: got %h want %h", i, pkts[i], pkt(3, i, 0, 77)); end
    end

    send_cmd(2'd0, 2'd0);
    for (w = 0; w < 10; w++) begin
      #1;
      if (done) break;
      @(posedge clk); #1;
    end
    n_checks++; if (w == 10) begin n_fail++; $display("FAIL clear_done: no done pulse within 10 cycles"); end
    @(posedge clk); #1;
    clear_shadow();

    for (int c = 2; c < 4; c++) begin
      send_cmd(2'd3, 2'(c));
      stream(1'b0, 1'b0);
      n_checks++; if (pkts.size() != NPIX) begin n_fail++; $display("FAIL clr_drain%0d_count: got %0d want %0d", c, pkts.size(), NPIX); end
      for (int i = 0; i < NPIX && i < pkts.size(); i++) begin
        n_checks++;
        if (pkts[i] !== pkt(c, i, 0, 0)) begin n_fail++; $display("FAIL clr_drain%0d_pkt[%0d]: got %h want %h", c, i, pkts[i], pkt(c, i, 0, 0)); end
      end
    end
  endtask

  task automatic test_reset_mid_step();
    int acc; int cyc;
    acc = 0;
    send_cmd(2'd2, 2'd1);
    out_ready = 1'b1;
    for (cyc = 0; cyc < 1000; cyc++) begin
      in_valid  = 1'b1;
      in_data   = 13'd5;
      cmd_valid = (cyc == 3);
      cmd_op    = 2'd0;
      #1;
      if (cyc == 3) begin
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL step_cmd_ready: got %b want 0", cmd_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL step_busy: got %b want 1", busy); end
      end
      if (in_valid && in_ready) acc++;
      if (acc == 101) break;
      @(posedge clk); #1;
    end
    n_checks++; if (acc != 101) begin n_fail++; $display("FAIL midrst_progress: accepted %0d want 101", acc); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_cmd_ready: got %b want 1", cmd_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_shadow();
    @(posedge clk); #1;

    send_cmd(2'd3, 2'd1);
    stream(1'b0, 1'b0);
    n_checks++; if (timeout_hit || done_cnt != 1) begin n_fail++; $display("FAIL midrst_drain_done: timeout=%0d pulses=%0d want 0/1", timeout_hit, done_cnt); end
    n_checks++; if (pkts.size() != NPIX) begin n_fail++; $display("FAIL midrst_drain_count: got %0d want %0d", pkts.size(), NPIX); end
    for (int i = 0; i < NPIX && i < pkts.size(); i++) begin
      n_checks++;
      if (pkts[i] !== pkt(1, i, 0, 0)) begin n_fail++; $display("FAIL midrst_drain_pkt[%0d]: got %h want %h", i, pkts[i], pkt(1, i, 0, 0)); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_drain_zero();
    test_load_step();
    test_saturation();
    test_backpressure();
    test_channel_isolation();
    test_reset_mid_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
